// File: rtl/prescaled_digit_counter.sv
// prescaled_digit_counter
//   A prescaler divides enabled clk cycles by PRESCALE; each prescaler
//   terminal cycle steps a modulo-DIGIT_MOD digit once.
//   Down counting is built only when PRESCALED_DIGIT_COUNTER_DOWN_EN is
//   defined. Otherwise the block counts up and up_dn is ignored.
//   Priority at the clock edge: reset > load > en.
module prescaled_digit_counter #(
   parameter int PRESCALE  = 11,
   parameter int DIGIT_MOD = 6,
   parameter int WIDTH     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tick,
   output logic             carry
);

   localparam int               PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    PRE_LAST   = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] DIGIT_LAST = WIDTH'(DIGIT_MOD - 1);
   // One extra bit so DIGIT_MOD == 2**WIDTH is representable.
   localparam logic [WIDTH:0]   MOD_EXT    = (WIDTH + 1)'(DIGIT_MOD);

   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             at_last;
   logic             up_wrap;
   logic             wrap;
   logic [WIDTH-1:0] step_val;
   logic [WIDTH-1:0] load_clamped;

`ifdef PRESCALED_DIGIT_COUNTER_DOWN_EN
   logic             dn_wrap;

   // Direction-dependent next digit and wrap detection.
   always_comb begin
      up_wrap = (out_q == DIGIT_LAST);
      dn_wrap = (out_q == '0);
      if (up_dn) begin
         wrap     = up_wrap;
         step_val = up_wrap ? '0 : out_q + WIDTH'(1);
      end else begin
         wrap     = dn_wrap;
         step_val = dn_wrap ? DIGIT_LAST : out_q - WIDTH'(1);
      end
   end
`else
   // Up-only build: up_dn is kept on the port but has no effect.
   logic unused_up_dn;
   assign unused_up_dn = up_dn;

   // Up-only next digit and wrap detection.
   always_comb begin
      up_wrap  = (out_q == DIGIT_LAST);
      wrap     = up_wrap;
      step_val = up_wrap ? '0 : out_q + WIDTH'(1);
   end
`endif

   // Terminal-cycle pulses; load and reset both suppress a step.
   always_comb begin
      at_last = (pre_q == PRE_LAST);
      tick    = en & ~load & ~reset & at_last;
      carry   = tick & wrap;
   end

   // Next-state for prescaler and digit: load overrides counting.
   always_comb begin
      pre_d        = pre_q;
      out_d        = out_q;
      load_clamped = ({1'b0, load_val} >= MOD_EXT) ? DIGIT_LAST : load_val;
      if (load) begin
         pre_d = '0;
         out_d = load_clamped;
      end else if (en) begin
         if (at_last) begin
            pre_d = '0;
            out_d = step_val;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q <= '0;
         out_q <= '0;
      end else begin
         pre_q <= pre_d;
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_prescaled_digit_counter.sv
// Bench for prescaled_digit_counter: a default-parameter instance (u0) and a
// PRESCALE=1 / DIGIT_MOD=10 instance (u1). Stimulus queues the expected
// out/tick/carry for a cycle; a monitor compares them at the falling edge.
module tb_prescaled_digit_counter;

`ifdef PRESCALED_DIGIT_COUNTER_DOWN_EN
   localparam bit DN = 1'b1;
`else
   localparam bit DN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       r0 = 1'b1, e0 = 1'b0, l0 = 1'b0, ud0 = 1'b1;
   logic [3:0] lv0 = '0;
   logic [3:0] out0;
   logic       tick0, carry0;
   logic       r1 = 1'b1, e1 = 1'b0, l1 = 1'b0, ud1 = 1'b1;
   logic [3:0] lv1 = '0;
   logic [3:0] out1;
   logic       tick1, carry1;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int         cyc;
      bit         d;
      logic [3:0] o;
      bit         t;
      bit         c;
      bit [95:0]  nm;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prescaled_digit_counter u0 (
      .clk(clk), .reset(r0), .en(e0), .up_dn(ud0), .load(l0),
      .load_val(lv0), .out(out0), .tick(tick0), .carry(carry0)
   );

   prescaled_digit_counter #(.PRESCALE(1), .DIGIT_MOD(10), .WIDTH(4)) u1 (
      .clk(clk), .reset(r1), .en(e1), .up_dn(ud1), .load(l1),
      .load_val(lv1), .out(out1), .tick(tick1), .carry(carry1)
   );

   task automatic drv0(input bit r, input bit e, input bit l, input logic [3:0] lv, input bit ud);
      @(posedge clk); #1;
      r0 = r; e0 = e; l0 = l; lv0 = lv; ud0 = ud;
   endtask

   task automatic drv1(input bit r, input bit e, input bit l, input logic [3:0] lv, input bit ud);
      @(posedge clk); #1;
      r1 = r; e1 = e; l1 = l; lv1 = lv; ud1 = ud;
   endtask

   task automatic expect_now(input bit [95:0] nm, input bit d, input logic [3:0] o, input bit t, input bit c);
      exp_t x;
      x.cyc = cyc; x.d = d; x.o = o; x.t = t; x.c = c; x.nm = nm;
      sb.push_back(x);
   endtask

   // Monitor: pops every expectation due this cycle and compares.
   always @(negedge clk) begin
      exp_t       x;
      logic [3:0] ao;
      logic       at, ac;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         x  = sb.pop_front();
         ao = x.d ? out1 : out0;
         at = x.d ? tick1 : tick0;
         ac = x.d ? carry1 : carry0;
         n_cmp++;
         if (x.cyc != cyc || ao !== x.o || at !== x.t || ac !== x.c) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got out=%0d tick=%0b carry=%0b, want out=%0d tick=%0b carry=%0b",
                     x.nm, x.d, cyc, ao, at, ac, x.o, x.t, x.c);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset; output is only defined after the first reset edge.
      drv0(1, 1, 0, 0, 1);
      drv0(1, 1, 0, 0, 1); expect_now("rst_hold", 0, 4'd0, 0, 0);

      // Free-running up count: step every 11 cycles, wrap 5->0 with carry.
      for (int k = 0; k <= 66; k++) begin
         drv0(0, 1, 0, 0, 1);
         expect_now("run_up", 0, 4'((k / 11) % 6), (k % 11) == 10,
                    ((k % 11) == 10) && ((k / 11) % 6) == 5);
      end

      // Reset together with load while out=4 mid-prescale.
      drv0(1, 0, 0, 0, 1); expect_now("rst2", 0, 4'd0, 0, 0);
      for (int k = 0; k <= 46; k++) begin
         drv0(0, 1, 0, 0, 1);
         expect_now("to_four", 0, 4'(k / 11), (k % 11) == 10, 0);
      end
      drv0(1, 1, 1, 4'd3, 1); expect_now("rst_load", 0, 4'd4, 0, 0);
      for (int k = 0; k <= 11; k++) begin
         drv0(0, 1, 0, 0, 1);
         expect_now("post_rst", 0, (k == 11) ? 4'd1 : 4'd0, k == 10, 0);
      end

      // Enable pause: 5 enabled, 7 held, step after 6 more enabled.
      drv0(1, 0, 0, 0, 1); expect_now("rst3", 0, 4'd1, 0, 0);
      for (int k = 0; k < 5; k++) begin
         drv0(0, 1, 0, 0, 1); expect_now("pre_pause", 0, 4'd0, 0, 0);
      end
      for (int k = 0; k < 7; k++) begin
         drv0(0, 0, 0, 0, 1); expect_now("paused", 0, 4'd0, 0, 0);
      end
      for (int j = 0; j <= 6; j++) begin
         drv0(0, 1, 0, 0, 1);
         expect_now("resume", 0, (j == 6) ? 4'd1 : 4'd0, j == 5, 0);
      end

      // Load: mid-prescale clear, clamp, and load beating a tick.
      drv0(1, 0, 0, 0, 1); expect_now("rst4", 0, 4'd1, 0, 0);
      for (int k = 0; k < 8; k++) begin
         drv0(0, 1, 0, 0, 1); expect_now("to_pre8", 0, 4'd0, 0, 0);
      end
      drv0(0, 1, 1, 4'd3, 1); expect_now("load3", 0, 4'd0, 0, 0);
      for (int k = 0; k <= 11; k++) begin
         drv0(0, 1, 0, 0, 1);
         expect_now("after_ld3", 0, (k == 11) ? 4'd4 : 4'd3, k == 10, 0);
      end
      drv0(0, 0, 1, 4'd9, 1); expect_now("load9", 0, 4'd4, 0, 0);
      for (int k = 0; k < 10; k++) begin
         drv0(0, 1, 0, 0, 1); expect_now("clamped5", 0, 4'd5, 0, 0);
      end
      drv0(0, 1, 1, 4'd2, 1); expect_now("ld_vs_tick", 0, 4'd5, 0, 0);
      drv0(0, 1, 0, 0, 1);    expect_now("ld_won", 0, 4'd2, 0, 0);
      drv0(1, 0, 0, 0, 1);

      // PRESCALE=1, DIGIT_MOD=10 instance.
      drv1(1, 1, 0, 0, 1); expect_now("d1_rst", 1, 4'd0, 0, 0);
      for (int k = 0; k <= 10; k++) begin
         drv1(0, 1, 0, 0, 1);
         expect_now("d1_up", 1, 4'(k % 10), 1, (k % 10) == 9);
      end
      drv1(0, 0, 0, 0, 1);     expect_now("d1_hold", 1, 4'd1, 0, 0);
      drv1(0, 1, 1, 4'd12, 1); expect_now("d1_ld12", 1, 4'd1, 0, 0);
      drv1(0, 1, 0, 0, 1);     expect_now("d1_clamp", 1, 4'd9, 1, 1);
      drv1(0, 1, 0, 0, 0);     expect_now("d1_dn0", 1, 4'd0, 1, DN);
      drv1(0, 1, 0, 0, 0);     expect_now("d1_dn1", 1, DN ? 4'd9 : 4'd1, 1, 0);
      drv1(0, 1, 0, 0, 0);     expect_now("d1_dn2", 1, DN ? 4'd8 : 4'd2, 1, 0);
      drv1(1, 1, 1, 4'd5, 0);  expect_now("d1_rstld", 1, DN ? 4'd7 : 4'd3, 0, 0);
      drv1(0, 0, 0, 0, 0);     expect_now("d1_rst_out", 1, 4'd0, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/prescaled_digit_counter.md
PRESCALED_DIGIT_COUNTER -- requirements
Module: prescaled_digit_counter

Interface
REQ-001 Parameter PRESCALE, default 11, SHALL set the number of enabled clk cycles per digit step; legal range 1..65535.
REQ-002 Parameter DIGIT_MOD, default 6, SHALL set the digit modulus; the digit range is 0..DIGIT_MOD-1; legal range 2..2^WIDTH.
REQ-003 Parameter WIDTH, default 4, SHALL set the digit width; legal range 1..16.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  count enable; prescaler and digit hold when low.
REQ-007 up_dn  input  1  direction: 1 = up, 0 = down (see Configuration).
REQ-008 load  input  1  synchronous digit load strobe.
REQ-009 load_val  input  WIDTH  value to load into the digit.
REQ-010 out  output  WIDTH  current digit value, registered.
REQ-011 tick  output  1  prescaler terminal pulse, combinational from registered state and en.
REQ-012 carry  output  1  digit wrap pulse, combinational from registered state, en and up_dn.

Function
REQ-013 The internal prescaler SHALL be ceil(log2(PRESCALE)) bits wide, minimum 1 bit, and SHALL count 0..PRESCALE-1.
REQ-014 tick SHALL be 1 exactly when en=1, load=0, reset=0 and prescaler==PRESCALE-1.
REQ-015 In a tick cycle the prescaler SHALL return to 0 and the digit SHALL step once at the same edge. Otherwise, with en=1, the prescaler SHALL increment by 1.
REQ-016 With PRESCALE=1, tick SHALL be 1 on every enabled cycle, and the digit SHALL step every enabled cycle.
REQ-017 Up step: out==DIGIT_MOD-1 -> 0; otherwise out+1.
REQ-018 Down step: out==0 -> DIGIT_MOD-1; otherwise out-1.
REQ-019 carry SHALL be 1 exactly in a tick cycle in which the step wraps, per REQ-017/018.
REQ-020 en=0 SHALL hold the prescaler and out unchanged and force tick=0 and carry=0; a pending prescaler phase SHALL resume when en returns to 1.
REQ-021 load=1 SHALL write load_val to out and clear the prescaler to 0 at the next edge, regardless of en; tick=0 and carry=0 in that cycle.
REQ-022 If load_val>=DIGIT_MOD, the loaded value SHALL be DIGIT_MOD-1 (clamp).
REQ-023 Priority SHALL be reset > load > en.
REQ-024 A change of up_dn SHALL take effect at the next tick, with no prescaler disturbance.

Reset
REQ-025 reset=1 at a rising edge SHALL clear the prescaler and out to 0, with no mid-operation residue.
REQ-026 While reset=1, tick and carry SHALL be 0.
REQ-027 The first step after reset release SHALL occur on the PRESCALE-th enabled cycle.

Configuration
REQ-028 Macro PRESCALED_DIGIT_COUNTER_DOWN_EN defined: up_dn SHALL be honoured per REQ-007/018.
REQ-029 Macro absent: the block SHALL count up only, and up_dn SHALL be ignored. The port SHALL remain present and no down-count logic SHALL be synthesised.

Verification
REQ-030 Default parameters, en=1, up: out SHALL be 1 after the 11th enabled edge. tick SHALL pulse every 11 cycles. Out SHALL wrap 5->0 with carry=1 on the 66th edge.
REQ-031 PRESCALE=1, DIGIT_MOD=10, WIDTH=4, DOWN_EN defined, up_dn=0 from out=0: the next edge SHALL give out=9 with carry=1 in the preceding cycle.
REQ-032 Default parameters: count 5 enabled cycles, drop en for 7 cycles, re-enable; the step SHALL occur after 6 more enabled cycles, with out unchanged while en=0.
REQ-033 Default parameters: load=1 with load_val=3 and prescaler=8 -> out=3 and prescaler=0. load_val=9 -> out=5. load and en both 1 -> load wins and tick=0.
REQ-034 Default parameters: assert reset with out=4 mid-prescale and load=1 simultaneously -> out=0, prescaler=0, tick=0 and carry=0. The first step SHALL occur 11 enabled cycles after release.
